// File: rtl/serial_rx_fifo_pkg.sv
// Shared definitions for the serial receiver: parity-mode encoding,
// receiver FSM states and the parity check helper.
package serial_rx_fifo_pkg;

   typedef enum logic [1:0] {
      PAR_NONE = 2'd0,
      PAR_EVEN = 2'd1,
      PAR_ODD  = 2'd2
   } parity_mode_t;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } rx_state_t;

   // x is the XOR of all data bits and the received parity bit
   function automatic logic parity_fail(input parity_mode_t mode, input logic x);
      logic fail;
      case (mode)
         PAR_EVEN: fail = x;
         PAR_ODD:  fail = ~x;
         default:  fail = 1'b0;
      endcase
      return fail;
   endfunction

endpackage

// File: rtl/serial_rx_fifo_fifo.sv
// Synchronous FIFO for received words. A write while full is accepted only
// when a read happens in the same cycle, so occupancy never exceeds DEPTH.
module serial_fifo
   import serial_rx_fifo_pkg::*;
#(
   parameter int WIDTH = 11,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wr_en,
   input  logic [WIDTH-1:0]           wr_data,
   input  logic                       rd_en,
   output logic [WIDTH-1:0]           rd_data,
   output logic                       empty,
   output logic                       full,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             wr_ok;
   logic             rd_ok;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign wr_ok   = wr_en & (~full | rd_en);
   assign rd_ok   = rd_en & ~empty;
   assign rd_data = mem[rd_ptr];

   // Storage array; not reset, the top gates the head with rdy
   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_ptr] <= wr_data;
   end

   // Pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + PW'(1);
         if (rd_ok) rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(wr_ok) - CW'(rd_ok);
      end
   end

endmodule

// File: rtl/serial_rx_fifo.sv
// Asynchronous serial receiver with a small word FIFO.
//
// state     | meaning
// ST_IDLE   | line idle, waiting for a synchronized falling edge
// ST_START  | timing to mid start bit; high there means glitch
// ST_DATA   | sampling DATA_BITS bits, LSB first
// ST_PARITY | sampling the parity bit (skipped when PARITY="none")
// ST_STOP   | sampling stop bit; on a low stop, wait for line high
module serial_rx_fifo
   import serial_rx_fifo_pkg::*;
#(
   parameter int DATA_BITS    = 8,
   parameter     PARITY       = "none",
   parameter int DIVISOR_BITS = 16,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [DIVISOR_BITS-1:0]         divisor,
   input  logic                            rx,
   output logic [DATA_BITS-1:0]            data,
   output logic                            err_frame,
   output logic                            err_parity,
   output logic                            err_overflow,
   output logic                            rdy,
   input  logic                            ack,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] level
);

   localparam parity_mode_t PAR_MODE = (PARITY == "even") ? PAR_EVEN :
                                       (PARITY == "odd")  ? PAR_ODD  : PAR_NONE;
   localparam int WW = DATA_BITS + 3;

   logic                    sync1, sync2, rx_prev;
   logic                    line, fall;
   rx_state_t               state_q, state_d;
   logic [DIVISOR_BITS-1:0] cnt_q, period_q;
   logic [3:0]              bit_idx;
   logic [DATA_BITS-1:0]    shreg;
   logic                    par_bit, wait_high;
   logic                    push_q, frame_q, perr_q, ovf_pend;
   logic                    tick;
   logic                    load_half, load_period, shift_en, cap_par, cap_stop;
   logic                    bit_inc, bit_clr;
   logic                    fifo_empty, fifo_full, drop;
   logic [WW-1:0]           wr_word, head;

   assign line = sync2;
   assign fall = rx_prev & ~sync2;
   assign tick = (cnt_q == '0);

   // Two-flop synchronizer plus one delay stage for falling-edge detection
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1   <= 1'b1;
         sync2   <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         sync1   <= rx;
         sync2   <= sync1;
         rx_prev <= sync2;
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Next-state and datapath control strobes
   always_comb begin
      state_d     = state_q;
      load_half   = 1'b0;
      load_period = 1'b0;
      shift_en    = 1'b0;
      cap_par     = 1'b0;
      cap_stop    = 1'b0;
      bit_inc     = 1'b0;
      bit_clr     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (fall) begin
               load_half = 1'b1;
               state_d   = ST_START;
            end
         end
         ST_START: begin
            if (tick) begin
               if (line) begin
                  state_d = ST_IDLE;
               end else begin
                  load_period = 1'b1;
                  bit_clr     = 1'b1;
                  state_d     = ST_DATA;
               end
            end
         end
         ST_DATA: begin
            if (tick) begin
               shift_en    = 1'b1;
               load_period = 1'b1;
               bit_inc     = 1'b1;
               if (bit_idx == 4'(DATA_BITS - 1))
                  state_d = (PAR_MODE == PAR_NONE) ? ST_STOP : ST_PARITY;
            end
         end
         ST_PARITY: begin
            if (tick) begin
               cap_par     = 1'b1;
               load_period = 1'b1;
               state_d     = ST_STOP;
            end
         end
         ST_STOP: begin
            if (wait_high) begin
               if (line) state_d = ST_IDLE;
            end else if (tick) begin
               cap_stop = 1'b1;
               if (line) state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Bit timer (down-counter), shift register and word capture
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q     <= '0;
         period_q  <= '0;
         bit_idx   <= '0;
         shreg     <= '0;
         par_bit   <= 1'b0;
         wait_high <= 1'b0;
         push_q    <= 1'b0;
         frame_q   <= 1'b0;
         perr_q    <= 1'b0;
      end else begin
         if (load_half) begin
            period_q <= divisor;
            cnt_q    <= (divisor >> 1) - DIVISOR_BITS'(1);
         end else if (load_period) begin
            cnt_q <= period_q - DIVISOR_BITS'(1);
         end else if (!tick) begin
            cnt_q <= cnt_q - DIVISOR_BITS'(1);
         end
         if (bit_clr)       bit_idx <= '0;
         else if (bit_inc)  bit_idx <= bit_idx + 4'd1;
         if (shift_en) shreg <= {line, shreg[DATA_BITS-1:1]};
         if (cap_par)  par_bit <= line;
         push_q <= cap_stop;
         if (cap_stop) begin
            frame_q <= ~line;
            perr_q  <= parity_fail(PAR_MODE, (^shreg) ^ par_bit);
         end
         if (cap_stop && !line)       wait_high <= 1'b1;
         else if (state_d == ST_IDLE) wait_high <= 1'b0;
      end
   end

   assign drop    = push_q & fifo_full & ~(rdy & ack);
   assign wr_word = {shreg, ovf_pend, frame_q, perr_q};

   // Overflow-pending: set by a dropped word, cleared by the next accepted push
   always_ff @(posedge clk) begin
      if (rst)         ovf_pend <= 1'b0;
      else if (push_q) ovf_pend <= drop | (ovf_pend & drop);
   end

   serial_fifo #(
      .WIDTH (WW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (push_q),
      .wr_data (wr_word),
      .rd_en   (ack),
      .rd_data (head),
      .empty   (fifo_empty),
      .full    (fifo_full),
      .count   (level)
   );

   assign rdy          = ~fifo_empty;
   assign data         = rdy ? head[WW-1:3] : '0;
   assign err_overflow = rdy & head[2];
   assign err_frame    = rdy & head[1];
   assign err_parity   = rdy & head[0];

endmodule

// File: tb/tb_serial_rx_fifo.sv
// Directed bench: one even-parity receiver for most scenarios and one
// odd-parity receiver for the odd parity error case.
module tb_serial_rx_fifo;
   import serial_rx_fifo_pkg::*;

   localparam int BIT = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] divisor;
   logic        rx_e, rx_o, ack_e, ack_o;
   logic [7:0]  data_e, data_o;
   logic        ferr_e, perr_e, oerr_e, rdy_e;
   logic        ferr_o, perr_o, oerr_o, rdy_o;
   logic [2:0]  level_e, level_o;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   serial_rx_fifo #(.DATA_BITS(8), .PARITY("even"), .DIVISOR_BITS(16), .FIFO_DEPTH(4)) u_even (
      .clk(clk), .rst(rst), .divisor(divisor), .rx(rx_e), .data(data_e),
      .err_frame(ferr_e), .err_parity(perr_e), .err_overflow(oerr_e),
      .rdy(rdy_e), .ack(ack_e), .level(level_e));

   serial_rx_fifo #(.DATA_BITS(8), .PARITY("odd"), .DIVISOR_BITS(16), .FIFO_DEPTH(4)) u_odd (
      .clk(clk), .rst(rst), .divisor(divisor), .rx(rx_o), .data(data_o),
      .err_frame(ferr_o), .err_parity(perr_o), .err_overflow(oerr_o),
      .rdy(rdy_o), .ack(ack_o), .level(level_o));

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_line(input int sel, input logic v);
      if (sel == 0) rx_e = v;
      else          rx_o = v;
   endtask

   task automatic hold_bit(input int sel, input logic v);
      set_line(sel, v);
      repeat (BIT) @(negedge clk);
   endtask

   task automatic send(input int sel, input logic [7:0] d, input logic pbit, input logic sbit);
      @(negedge clk);
      hold_bit(sel, 1'b0);
      for (int i = 0; i < 8; i++) hold_bit(sel, d[i]);
      hold_bit(sel, pbit);
      hold_bit(sel, sbit);
      set_line(sel, 1'b1);
      repeat (24) @(negedge clk);
   endtask

   task automatic pop(input int sel);
      if (sel == 0) ack_e = 1'b1;
      else          ack_o = 1'b1;
      @(negedge clk);
      ack_e = 1'b0;
      ack_o = 1'b0;
   endtask

   task automatic check_head(input string tag, input logic [7:0] d,
                             input logic fe, input logic pe, input logic oe);
      check_eq({tag, "_rdy"},  32'(rdy_e),  32'd1);
      check_eq({tag, "_data"}, 32'(data_e), 32'(d));
      check_eq({tag, "_ferr"}, 32'(ferr_e), 32'(fe));
      check_eq({tag, "_perr"}, 32'(perr_e), 32'(pe));
      check_eq({tag, "_oerr"}, 32'(oerr_e), 32'(oe));
   endtask

   initial begin
      rst     = 1'b1;
      divisor = 16'd16;
      rx_e    = 1'b1;
      rx_o    = 1'b1;
      ack_e   = 1'b0;
      ack_o   = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      check_eq("rst_rdy",   32'(rdy_e),   32'd0);
      check_eq("rst_level", 32'(level_e), 32'd0);
      check_eq("rst_data",  32'(data_e),  32'd0);
      check_eq("rst_errs",  32'({ferr_e, perr_e, oerr_e}), 32'd0);

      // 0xA5 even parity: four ones -> parity bit 0
      send(0, 8'hA5, 1'b0, 1'b1);
      check_head("a5", 8'hA5, 1'b0, 1'b0, 1'b0);
      check_eq("a5_level", 32'(level_e), 32'd1);
      pop(0);
      check_eq("a5_pop_level", 32'(level_e), 32'd0);
      check_eq("a5_pop_rdy",   32'(rdy_e),   32'd0);

      // 0x3C with stop bit low, then clean 0x11
      send(0, 8'h3C, 1'b0, 1'b0);
      check_head("3c", 8'h3C, 1'b1, 1'b0, 1'b0);
      pop(0);
      send(0, 8'h11, 1'b0, 1'b1);
      check_head("11", 8'h11, 1'b0, 1'b0, 1'b0);
      pop(0);

      // odd parity: 0x01 needs parity bit 0, send 1
      send(1, 8'h01, 1'b1, 1'b1);
      check_eq("odd_rdy",  32'(rdy_o),  32'd1);
      check_eq("odd_data", 32'(data_o), 32'h01);
      check_eq("odd_perr", 32'(perr_o), 32'd1);
      check_eq("odd_ferr", 32'(ferr_o), 32'd0);
      pop(1);

      // overflow: 6 words into a 4-deep FIFO, parity bits hand computed
      send(0, 8'h10, 1'b1, 1'b1);
      send(0, 8'h11, 1'b0, 1'b1);
      send(0, 8'h12, 1'b0, 1'b1);
      send(0, 8'h13, 1'b1, 1'b1);
      send(0, 8'h14, 1'b0, 1'b1);
      send(0, 8'h15, 1'b1, 1'b1);
      check_eq("ovf_level", 32'(level_e), 32'd4);
      check_head("ovf_h0", 8'h10, 1'b0, 1'b0, 1'b0);
      pop(0);
      check_head("ovf_h1", 8'h11, 1'b0, 1'b0, 1'b0);
      pop(0);
      check_head("ovf_h2", 8'h12, 1'b0, 1'b0, 1'b0);
      pop(0);
      check_head("ovf_h3", 8'h13, 1'b0, 1'b0, 1'b0);
      pop(0);
      check_eq("ovf_drained", 32'(level_e), 32'd0);
      send(0, 8'h20, 1'b1, 1'b1);
      check_head("ovf_20", 8'h20, 1'b0, 1'b0, 1'b1);
      pop(0);
      send(0, 8'h21, 1'b0, 1'b1);
      check_head("ovf_21", 8'h21, 1'b0, 1'b0, 1'b0);
      pop(0);

      // 5-cycle glitch on the line
      set_line(0, 1'b0);
      repeat (5) @(negedge clk);
      set_line(0, 1'b1);
      repeat (40) @(negedge clk);
      check_eq("glitch_rdy",   32'(rdy_e),   32'd0);
      check_eq("glitch_level", 32'(level_e), 32'd0);
      check_eq("glitch_state", 32'(u_even.state_q), 32'(ST_IDLE));

      // reset mid-frame with two words buffered
      send(0, 8'h55, 1'b0, 1'b1);
      send(0, 8'h66, 1'b0, 1'b1);
      check_eq("mid_level_pre", 32'(level_e), 32'd2);
      @(negedge clk);
      hold_bit(0, 1'b0);
      hold_bit(0, 1'b1);
      hold_bit(0, 1'b0);
      check_eq("mid_in_data", 32'(u_even.state_q), 32'(ST_DATA));
      rst = 1'b1;
      set_line(0, 1'b1);
      @(negedge clk);
      rst = 1'b0;
      check_eq("mid_level", 32'(level_e), 32'd0);
      check_eq("mid_rdy",   32'(rdy_e),   32'd0);
      check_eq("mid_data",  32'(data_e),  32'd0);
      repeat (200) @(negedge clk);
      check_eq("mid_no_partial", 32'(level_e), 32'd0);
      send(0, 8'h7E, 1'b0, 1'b1);
      check_head("7e", 8'h7E, 1'b0, 1'b0, 1'b0);
      check_eq("7e_level", 32'(level_e), 32'd1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/serial_rx_fifo.md
SERIAL_RX_FIFO -- requirements
Module: serial_rx_fifo

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, number of data bits per frame (5..9).
REQ-002 SHALL have parameter PARITY, default "none", parity mode: one of "none", "even" or "odd".
REQ-003 SHALL have parameter DIVISOR_BITS, default 16, width of the divisor port.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, received-word buffer depth (power of two, >=2).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on the positive edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port divisor, input, DIVISOR_BITS bits: clk cycles per bit period (valid range >=4).
REQ-008 SHALL have port rx, input, 1 bit: the asynchronous serial line, idle high.
REQ-009 SHALL have port data, output, DATA_BITS bits: the head word of the FIFO.
REQ-010 SHALL have port err_frame, output, 1 bit: the head word had a low stop bit.
REQ-011 SHALL have port err_parity, output, 1 bit: the head word failed its parity check (always 0 when PARITY="none").
REQ-012 SHALL have port err_overflow, output, 1 bit: one or more words were dropped before the head word.
REQ-013 SHALL have port rdy, output, 1 bit: the FIFO is non-empty and the head is valid.
REQ-014 SHALL have port ack, input, 1 bit: consumer accepts the head word.
REQ-015 SHALL have port level, output, clog2(FIFO_DEPTH+1) bits: current FIFO occupancy.

Function
REQ-016 SHALL pass rx through a 2-flop synchronizer; both flops reset to 1; all line decisions use the synchronized value.
REQ-017 SHALL implement the receiver FSM with states IDLE, START, DATA, PARITY, STOP; PARITY is skipped when PARITY="none".
REQ-018 SHALL leave IDLE on a synchronized high-to-low transition, latch divisor into an internal period register, and enter START.
REQ-019 SHALL sample the line in START at floor(period/2) cycles after the edge; if high, SHALL return to IDLE (glitch, no word, no error).
REQ-020 SHALL take each following sample exactly period cycles after the previous sample.
REQ-021 SHALL shift DATA_BITS samples LSB first in DATA, then take one parity sample, then one stop sample.
REQ-022 SHALL set err_parity for the word when the XOR of data and parity bit is 1 ("even") or 0 ("odd").
REQ-023 SHALL set err_frame for the word when the stop sample is 0; in that case SHALL return to IDLE only after the line is seen high.
REQ-024 SHALL push {data, err_frame, err_parity} into the FIFO in the cycle after the stop sample; rdy SHALL rise one cycle later when the FIFO was empty.
REQ-025 SHALL ignore divisor changes mid-frame; the new value applies from the next start edge.
REQ-026 SHALL pop the head on a cycle with rdy=1 and ack=1; ack while rdy=0 SHALL have no effect.
REQ-027 SHALL keep data and err_* stable while rdy=1 and ack=0.
REQ-028 SHALL drop an incoming word when the FIFO is full and no pop occurs in that cycle, and SHALL set an internal overflow-pending flag.
REQ-029 SHALL accept the push on a simultaneous push and pop when full; level SHALL be unchanged and no overflow SHALL occur.
REQ-030 SHALL attach overflow-pending to the next word pushed: that entry reads err_overflow=1, and the flag clears on that push.
REQ-031 SHALL wrap read and write pointers modulo FIFO_DEPTH, and level SHALL never exceed FIFO_DEPTH.

Reset
REQ-032 SHALL, on rst=1 at a clock edge, return the FSM to IDLE and clear the FIFO, level and overflow-pending.
REQ-033 SHALL drive rdy=0, err_*=0 and data=0 in the cycle after reset.
REQ-034 SHALL discard a frame in progress when reset arrives mid-frame, and SHALL not push a partial word.

Structure
REQ-035 SHALL place the parity-mode encoding and the FSM state enumeration in the shared serial package.
REQ-036 SHALL use one sub-module, serial_fifo: a synchronous FIFO with width DATA_BITS+3 and depth FIFO_DEPTH.

Verification
REQ-037 SHALL cover: divisor=16, PARITY="even", byte 0xA5 with correct parity -> rdy, data=0xA5, err_*=0, ack pops and level returns to 0.
REQ-038 SHALL cover: 0x3C sent with stop bit low -> err_frame=1, err_parity=0, then the next byte 0x11 is received clean.
REQ-039 SHALL cover: PARITY="odd", 0x01 with a wrong parity bit -> err_parity=1.
REQ-040 SHALL cover: FIFO_DEPTH=4, 6 bytes 0x10..0x15 with no ack -> level=4 holding 0x10..0x13; after draining, byte 0x20 reads err_overflow=1 and the following byte reads 0.
REQ-041 SHALL cover: an rx low pulse of 5 cycles at divisor=16 -> no word, FSM back in IDLE.
REQ-042 SHALL cover: rst asserted during the DATA state of a frame, with 2 words in the FIFO -> level=0 and rdy=0 next cycle, and a following byte 0x7E is received correctly.
